ch_cmd_scheduler: RTL and testbench
===================================

# ch_cmd_scheduler

- Sits between the UART command decoder and the CH_NUM serial-out channels.
- Takes each decoded command, together with its `done_tick`, into a one-entry pending buffer.
- Sequences stop, drain, load and start strobes to the channel chosen by `sel_out`, and drives the shared channel-configuration bus.
- Reports completion, invalid selects, drain timeouts and dropped commands.

## Interface

- `DATA_BIT`, 32: width of the pattern and frequency buses.
- `CH_NUM`, 4: number of channels, 1..16.
- `TIMEOUT`, 65535: maximum drain wait in cycles, 16-bit value.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `cmd_valid_i`  in  1  command strobe, one cycle (decoder `done_tick`).
- `output_pattern_i`  in  DATA_BIT  output pattern.
- `freq_pattern_i`  in  DATA_BIT  per-bit fast/slow select.
- `sel_out_i`  in  4  target channel index.
- `start_i`, `stop_i`, `mode_i`  in  1 each  command flags.
- `slow_period_i`, `fast_period_i`  in  8 each  bit periods.
- `ch_busy_i`  in  CH_NUM  per-channel busy.
- `ch_pattern_o`  out  DATA_BIT  shared configuration bus.
- `ch_freq_o`  out  DATA_BIT  shared configuration bus.
- `ch_mode_o`  out  1  shared configuration bus.
- `ch_slow_o`, `ch_fast_o`  out  8 each  shared configuration bus.
- `ch_load_o`  out  CH_NUM  one-hot load strobe.
- `ch_start_o`  out  CH_NUM  one-hot start strobe.
- `ch_stop_o`  out  CH_NUM  one-hot stop strobe.
- `done_tick_o`  out  1  command finished.
- `cmd_err_o`  out  1  error pulse (bad select or timeout).
- `ovf_o`  out  1  command dropped.
- `busy_o`  out  1  scheduler not in S_IDLE.

## Operation

- **Active register.** Holds all command fields.
  - The configuration buses drive the active register continuously.
  - The buses change only when the scheduler leaves S_IDLE with a new command.
- **Pending buffer.** One entry: fields plus a valid bit.
  - `cmd_valid_i` outside S_IDLE with pending empty: store it in pending.
  - `cmd_valid_i` outside S_IDLE with pending full: drop it and pulse `ovf_o` for one cycle.
- **S_IDLE.**
  - Pending valid: move pending to active, clear pending, go to S_DECODE. A simultaneous `cmd_valid_i` writes into pending.
  - Otherwise, `cmd_valid_i`: load active directly, go to S_DECODE.
- **S_DECODE.**
  - `sel >= CH_NUM`: pulse `cmd_err_o`, go to S_IDLE. No `done_tick_o`.
  - Else if `stop`: go to S_STOP.
  - Else if `ch_busy_i[sel]`: go to S_DRAIN.
  - Else: go to S_LOAD.
- **S_STOP.** Assert `ch_stop_o[sel]`, go to S_DRAIN.
- **S_DRAIN.** Counter counts up from 0 while `ch_busy_i[sel]` is high.
  - Busy low: if `stop` and not `start`, go to S_DONE; else go to S_LOAD.
  - With timeout (see Configuration): counter reaching TIMEOUT pulses `cmd_err_o` and returns to S_IDLE. No `done_tick_o`.
- **S_LOAD.** Assert `ch_load_o[sel]`. If `start`, go to S_START; else go to S_DONE.
- **S_START.** Assert `ch_start_o[sel]`, go to S_DONE.
- **S_DONE.** Assert `done_tick_o`, go to S_IDLE.
- **Command types.**
  - Stop only: stop, drain, done. No load.
  - Neither flag: configuration update only; drains first if the channel is busy.
- **Strobes.** Strobes and ticks are decoded from the state register. Every strobe is exactly one cycle and one-hot.
- **Unused states.** Go to S_IDLE.

## Timing

- **Reset.** All outputs 0; state S_IDLE; pending valid 0; active register 0; drain counter 0. Reset mid-sequence aborts with no further strobes.
- **Start to idle channel.** Command strobe in cycle 0.
  - Cycle 1: S_DECODE.
  - Cycle 2: `ch_load_o`.
  - Cycle 3: `ch_start_o`.
  - Cycle 4: `done_tick_o`.
  - Cycle 5: S_IDLE, ready for the next command.
- **Stop then start, channel busy N cycles after the stop.**
  - `ch_stop_o` in cycle 2.
  - `ch_load_o` one cycle after the first cycle in which busy is sampled low.
- **Bus validity.** The configuration bus is stable from S_DECODE through S_DONE, so it is valid at `ch_load_o`.
- **`busy_o`.** High in every state except S_IDLE.

## Configuration

- `DRAIN_TIMEOUT_EN` defined: drain counter and timeout exit are present as described.
- Undefined: no counter. S_DRAIN waits indefinitely for `ch_busy_i[sel]` low, and `cmd_err_o` fires only for a bad select.

## Test plan

- Start command, `sel=2`, channel idle, pattern `0xA5A5A5A5` -> `ch_load_o=4'b0100` at cycle 2, `ch_start_o=4'b0100` at cycle 3, `done_tick_o` at cycle 4, `ch_pattern_o=0xA5A5A5A5`.
- Stop+start, `sel=1`, busy held 10 cycles after the stop -> stop at cycle 2, load at 2 + 10 + 2, then start, then done.
- `sel=5` with CH_NUM=4 -> `cmd_err_o` at cycle 1, no strobes, no done.
- Three back-to-back commands one cycle apart -> the first executes, the second runs from pending, the third pulses `ovf_o`.
- Timeout build, TIMEOUT=8, busy held high -> `cmd_err_o` after 8 drain cycles, S_IDLE. Non-timeout build: still waiting after 100 cycles.
- Reset asserted in S_DRAIN -> all outputs 0 immediately; a new command afterwards executes normally.

Source files
------------

// File: rtl/ch_cmd_scheduler.sv
// ch_cmd_scheduler: sequences one decoded UART command at a time onto one of CH_NUM
// serial-out channels.
//
// The sequence is stop -> drain -> load -> start -> done. Each strobe is one cycle
// and one-hot on the selected channel.
//
// A single pending slot absorbs one command that arrives while a sequence runs.
// A further command that arrives while the slot is full is dropped and flagged on
// ovf_o.
//
// Optional feature: define DRAIN_TIMEOUT_EN to bound the drain wait to TIMEOUT
// cycles. When the bound is hit, cmd_err_o pulses and the command is abandoned.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cmd_valid_i              one-cycle command strobe (decoder done_tick)
//   output_pattern_i         command pattern field
//   freq_pattern_i           command per-bit fast/slow field
//   sel_out_i                command target channel field
//   start_i, stop_i, mode_i  command flag fields
//   slow_period_i            command slow bit-period field
//   fast_period_i            command fast bit-period field
//   ch_busy_i                per-channel busy
//   ch_pattern_o, ch_freq_o, ch_mode_o, ch_slow_o, ch_fast_o
//                            shared channel-configuration bus (active command)
//   ch_load_o, ch_start_o, ch_stop_o
//                            one-hot channel strobes
//   done_tick_o              command finished
//   cmd_err_o                bad select or drain timeout
//   ovf_o                    command dropped
//   busy_o                   scheduler not idle
module ch_cmd_scheduler #(
  parameter int unsigned DATA_BIT = 32,
  parameter int unsigned CH_NUM   = 4,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  input  logic [DATA_BIT-1:0] output_pattern_i,
  input  logic [DATA_BIT-1:0] freq_pattern_i,
  input  logic [3:0]          sel_out_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                mode_i,
  input  logic [7:0]          slow_period_i,
  input  logic [7:0]          fast_period_i,
  input  logic [CH_NUM-1:0]   ch_busy_i,
  output logic [DATA_BIT-1:0] ch_pattern_o,
  output logic [DATA_BIT-1:0] ch_freq_o,
  output logic                ch_mode_o,
  output logic [7:0]          ch_slow_o,
  output logic [7:0]          ch_fast_o,
  output logic [CH_NUM-1:0]   ch_load_o,
  output logic [CH_NUM-1:0]   ch_start_o,
  output logic [CH_NUM-1:0]   ch_stop_o,
  output logic                done_tick_o,
  output logic                cmd_err_o,
  output logic                ovf_o,
  output logic                busy_o
);

  typedef struct packed {
    logic [DATA_BIT-1:0] pat;
    logic [DATA_BIT-1:0] freq;
    logic [3:0]          sel;
    logic                start;
    logic                stop;
    logic                mode;
    logic [7:0]          slow;
    logic [7:0]          fast;
  } cmd_t;

  typedef enum logic [2:0] {
    StIdle, StDecode, StStop, StDrain, StLoad, StStart, StDone
  } state_e;

  state_e state_q, state_d;
  cmd_t   act_q, pend_q, cmd_in;
  logic   pend_vld_q;
  logic   ovf_q;

  logic        sel_ok, busy_sel, timeout;
  logic [15:0] busy_pad, sel_dec;
  logic [CH_NUM-1:0] sel_hot;

  assign cmd_in = '{pat: output_pattern_i, freq: freq_pattern_i, sel: sel_out_i,
                    start: start_i, stop: stop_i, mode: mode_i,
                    slow: slow_period_i, fast: fast_period_i};

  assign sel_ok   = {1'b0, act_q.sel} < 5'(CH_NUM);
  assign busy_pad = 16'(ch_busy_i);
  // Channels beyond CH_NUM read as not busy; they never reach the drain state anyway.
  assign busy_sel = busy_pad[act_q.sel];
  assign sel_dec  = 16'(1) << act_q.sel;
  assign sel_hot  = sel_dec[CH_NUM-1:0];

`ifdef DRAIN_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // The counter runs only while in drain with the channel busy. It restarts from 0
  // on each drain entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == StDrain && busy_sel) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // The TIMEOUT-th consecutive busy cycle in drain gives up.
  assign timeout = busy_sel && (cnt_q == 16'(TIMEOUT - 1));
`else
  // No drain limit in this build; the drain wait is unbounded.
  assign timeout = (TIMEOUT == 0) && 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Command storage: active register and one-entry pending buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (state_q == StIdle) begin
        if (pend_vld_q) begin
          act_q      <= pend_q;
          pend_vld_q <= cmd_valid_i;
          if (cmd_valid_i) pend_q <= cmd_in;
        end else if (cmd_valid_i) begin
          act_q <= cmd_in;
        end
      end else if (cmd_valid_i) begin
        if (!pend_vld_q) begin
          pend_q     <= cmd_in;
          pend_vld_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (pend_vld_q || cmd_valid_i) state_d = StDecode;
      StDecode: begin
        if (!sel_ok)          state_d = StIdle;
        else if (act_q.stop)  state_d = StStop;
        else if (busy_sel)    state_d = StDrain;
        else                  state_d = StLoad;
      end
      StStop:   state_d = StDrain;
      StDrain: begin
        if (!busy_sel)    state_d = (act_q.stop && !act_q.start) ? StDone : StLoad;
        else if (timeout) state_d = StIdle;
      end
      StLoad:   state_d = act_q.start ? StStart : StDone;
      StStart:  state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs, decoded from the state register and the active command
  always_comb begin
    ch_load_o   = '0;
    ch_start_o  = '0;
    ch_stop_o   = '0;
    done_tick_o = 1'b0;
    cmd_err_o   = 1'b0;
    unique case (state_q)
      StDecode: cmd_err_o   = !sel_ok;
      StStop:   ch_stop_o   = sel_hot;
      StDrain:  cmd_err_o   = timeout;
      StLoad:   ch_load_o   = sel_hot;
      StStart:  ch_start_o  = sel_hot;
      StDone:   done_tick_o = 1'b1;
      default:  ;
    endcase
  end

  assign busy_o       = (state_q != StIdle);
  assign ovf_o        = ovf_q;
  assign ch_pattern_o = act_q.pat;
  assign ch_freq_o    = act_q.freq;
  assign ch_mode_o    = act_q.mode;
  assign ch_slow_o    = act_q.slow;
  assign ch_fast_o    = act_q.fast;

endmodule

// File: tb/tb_ch_cmd_scheduler.sv
module tb_ch_cmd_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic [31:0] output_pattern_i = '0;
  logic [31:0] freq_pattern_i = '0;
  logic [3:0]  sel_out_i = '0;
  logic        start_i = 1'b0, stop_i = 1'b0, mode_i = 1'b0;
  logic [7:0]  slow_period_i = '0, fast_period_i = '0;
  logic [3:0]  ch_busy_i = '0;
  logic [31:0] ch_pattern_o, ch_freq_o;
  logic        ch_mode_o;
  logic [7:0]  ch_slow_o, ch_fast_o;
  logic [3:0]  ch_load_o, ch_start_o, ch_stop_o;
  logic        done_tick_o, cmd_err_o, ovf_o, busy_o;

  ch_cmd_scheduler #(.DATA_BIT(32), .CH_NUM(4), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i),
    .output_pattern_i(output_pattern_i), .freq_pattern_i(freq_pattern_i),
    .sel_out_i(sel_out_i), .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
    .slow_period_i(slow_period_i), .fast_period_i(fast_period_i), .ch_busy_i(ch_busy_i),
    .ch_pattern_o(ch_pattern_o), .ch_freq_o(ch_freq_o), .ch_mode_o(ch_mode_o),
    .ch_slow_o(ch_slow_o), .ch_fast_o(ch_fast_o), .ch_load_o(ch_load_o),
    .ch_start_o(ch_start_o), .ch_stop_o(ch_stop_o), .done_tick_o(done_tick_o),
    .cmd_err_o(cmd_err_o), .ovf_o(ovf_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // Per-command monitor
  int cyc;
  int busy_ch, busy_lo, busy_hi;
  int first_load, first_start, first_stop, first_done, first_err;
  int n_load, n_start, n_stop, n_done, n_err, n_ovf, n_hot;
  logic [3:0]  load_val, start_val, stop_val;
  logic [31:0] pat_at_load;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon(input int ch, input int lo, input int hi);
    cyc = 0;
    busy_ch = ch; busy_lo = lo; busy_hi = hi;
    first_load = -1; first_start = -1; first_stop = -1; first_done = -1; first_err = -1;
    n_load = 0; n_start = 0; n_stop = 0; n_done = 0; n_err = 0; n_ovf = 0; n_hot = 0;
    load_val = '0; start_val = '0; stop_val = '0; pat_at_load = '0;
  endtask

  task automatic issue(input logic [3:0] sel, input logic st, input logic sp,
                       input logic [31:0] pat);
    output_pattern_i = pat;
    freq_pattern_i   = ~pat;
    sel_out_i        = sel;
    start_i          = st;
    stop_i           = sp;
    mode_i           = 1'b1;
    slow_period_i    = 8'h10;
    fast_period_i    = 8'h02;
    cmd_valid_i      = 1'b1;
  endtask

  // Advance one cycle, apply the busy schedule, then record what the DUT shows.
  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    cmd_valid_i = 1'b0;
    ch_busy_i = '0;
    if (cyc >= busy_lo && cyc <= busy_hi) ch_busy_i[busy_ch] = 1'b1;
    #1;
    if (ch_load_o != 0) begin
      if (first_load < 0) first_load = cyc;
      n_load++; load_val = ch_load_o; pat_at_load = ch_pattern_o;
      if ($countones(ch_load_o) != 1) n_hot++;
    end
    if (ch_start_o != 0) begin
      if (first_start < 0) first_start = cyc;
      n_start++; start_val = ch_start_o;
      if ($countones(ch_start_o) != 1) n_hot++;
    end
    if (ch_stop_o != 0) begin
      if (first_stop < 0) first_stop = cyc;
      n_stop++; stop_val = ch_stop_o;
      if ($countones(ch_stop_o) != 1) n_hot++;
    end
    if (done_tick_o) begin
      if (first_done < 0) first_done = cyc;
      n_done++;
    end
    if (cmd_err_o) begin
      if (first_err < 0) first_err = cyc;
      n_err++;
    end
    if (ovf_o) n_ovf++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_strobes", 32'({ch_load_o, ch_start_o, ch_stop_o, done_tick_o, cmd_err_o,
                                 ovf_o, busy_o}), 32'd0);
    check_eq("rst_pattern", ch_pattern_o, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // Start to idle channel 2
    clr_mon(0, 1, 0);
    issue(4'd2, 1'b1, 1'b0, 32'hA5A5A5A5);
    run(6);
    check_eq("s1_load_cyc", first_load, 2);
    check_eq("s1_start_cyc", first_start, 3);
    check_eq("s1_done_cyc", first_done, 4);
    check_eq("s1_load_val", 32'(load_val), 32'h4);
    check_eq("s1_start_val", 32'(start_val), 32'h4);
    check_eq("s1_pat_at_load", pat_at_load, 32'hA5A5A5A5);
    check_eq("s1_freq", ch_freq_o, 32'h5A5A5A5A);
    check_eq("s1_counts", 32'({n_load, n_start, n_stop, n_done, n_err}),
             32'({32'd1, 32'd1, 32'd0, 32'd1, 32'd0}));
    check_eq("s1_idle", 32'(busy_o), 32'd0);

    // Stop+start to channel 1, busy for 10 cycles after the stop strobe
    clr_mon(1, 3, 12);
    issue(4'd1, 1'b1, 1'b1, 32'h12345678);
    run(18);
    check_eq("s2_stop_cyc", first_stop, 2);
    check_eq("s2_stop_val", 32'(stop_val), 32'h2);
    check_eq("s2_load_cyc", first_load, 14);
    check_eq("s2_start_cyc", first_start, 15);
    check_eq("s2_done_cyc", first_done, 16);

    // Stop only, channel 3 idle: stop, drain, done, no load
    clr_mon(3, 1, 0);
    issue(4'd3, 1'b0, 1'b1, 32'h0);
    run(6);
    check_eq("s3_stop_cyc", first_stop, 2);
    check_eq("s3_done_cyc", first_done, 4);
    check_eq("s3_no_load", n_load + n_start, 0);

    // Bad select
    clr_mon(0, 1, 0);
    issue(4'd5, 1'b1, 1'b0, 32'hFFFF0000);
    run(5);
    check_eq("s4_err_cyc", first_err, 1);
    check_eq("s4_no_strobes", n_load + n_start + n_stop + n_done, 0);

    // Three back-to-back commands
    clr_mon(0, 1, 0);
    issue(4'd0, 1'b1, 1'b0, 32'h1);
    step();
    issue(4'd1, 1'b1, 1'b0, 32'h2);
    step();
    issue(4'd2, 1'b1, 1'b0, 32'h3);
    run(12);
    check_eq("s5_ovf", n_ovf, 1);
    check_eq("s5_done", n_done, 2);
    check_eq("s5_loads", n_load, 2);
    check_eq("s5_first_load", first_load, 2);
    check_eq("s5_second_load", 32'(load_val), 32'h2);
    check_eq("s5_second_pat", pat_at_load, 32'h2);
    check_eq("s5_hot", n_hot, 0);

    // Drain with channel 0 held busy
    clr_mon(0, 1, 100000);
    issue(4'd0, 1'b1, 1'b0, 32'hCAFE);
`ifdef DRAIN_TIMEOUT_EN
    run(14);
    check_eq("s6_err_cyc", first_err, 9);
    check_eq("s6_err_cnt", n_err, 1);
    check_eq("s6_no_load", n_load + n_done, 0);
    check_eq("s6_idle", 32'(busy_o), 32'd0);
`else
    run(100);
    check_eq("s6_waiting", 32'(busy_o), 32'd1);
    check_eq("s6_no_err", n_err + n_load + n_done, 0);
`endif

    // Reset while draining
    clr_mon(1, 1, 100000);
    issue(4'd1, 1'b1, 1'b0, 32'hBEEF);
    run(4);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("s7_rst_strobes", 32'({ch_load_o, ch_start_o, ch_stop_o, done_tick_o, cmd_err_o,
                                    ovf_o, busy_o}), 32'd0);
    check_eq("s7_rst_pattern", ch_pattern_o, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    clr_mon(0, 1, 0);
    issue(4'd2, 1'b1, 1'b0, 32'h0F0F0F0F);
    run(6);
    check_eq("s7_load_cyc", first_load, 2);
    check_eq("s7_done_cyc", first_done, 4);
    check_eq("s7_pat", pat_at_load, 32'h0F0F0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
